// File: rtl/usb_tx_bit_stuffer_pkg.sv
// ---------------------------------------------------------------------------
// usb_tx_bit_stuffer_pkg
//   Shared USB2 transmit-path definitions: the TX state encodings, the USB
//   bit-stuffing run length and the packet byte width. The NRZI encoder and
//   the packet/EOP sequencer import the same package, so all three agree on
//   these values.
//
//   Contents:
//     tx_state_e     IDLE / SHIFT / STUFF transmit states
//     USB_STUFF_LEN  consecutive 1s after which a 0 is inserted (6)
//     USB_BYTE_W     packet byte width (8)
// ---------------------------------------------------------------------------
package usb_tx_bit_stuffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STUFF = 2'd2
    } tx_state_e;

    localparam int USB_STUFF_LEN = 6;
    localparam int USB_BYTE_W    = 8;

endpackage

// File: rtl/usb_tx_bit_stuffer.sv
// ---------------------------------------------------------------------------
// usb_tx_bit_stuffer
//   Transmit stage in front of the NRZI encoder. It accepts packet bytes over
//   a valid/ready handshake and serializes each byte LSB first, emitting one
//   bit per bit_en strobe. After every STUFF_LEN consecutive 1s it inserts a
//   0 stuff bit, and this includes the end of a packet.
//
//   Ports:
//     clk         clock
//     rst_b       synchronous active-low reset
//     bit_en      bit-rate strobe; at most one output bit per strobe
//     byte_in     packet byte
//     byte_last   byte_in is the final byte of the packet
//     byte_valid  byte_in / byte_last valid
//     byte_ready  byte is taken on a cycle where byte_valid & byte_ready
//     dout        serialized and stuffed bit (to NRZI din)
//     dout_valid  one-cycle pulse per emitted bit (to NRZI din_valid)
//     busy        packet in progress
//     pkt_done    pulse that coincides with the final dout_valid
//     underrun    pulse: the next byte was missing mid-packet
// ---------------------------------------------------------------------------
module usb_tx_bit_stuffer
    import usb_tx_bit_stuffer_pkg::*;
#(
    parameter int DATA_W    = USB_BYTE_W,
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_last,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              pkt_done,
    output logic              underrun
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(STUFF_LEN - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              last_q, last_d;
    logic              stuff_at_end_q, stuff_at_end_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  ones_cnt_q, ones_cnt_d;
    logic              dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              pkt_done_q, pkt_done_d;
    logic              underrun_q, underrun_d;

    logic cur_bit;
    logic stuff_next;
    logic load_slot;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            last_q         <= 1'b0;
            stuff_at_end_q <= 1'b0;
            bit_idx_q      <= '0;
            ones_cnt_q     <= '0;
            dout_q         <= 1'b1;
            dout_valid_q   <= 1'b0;
            pkt_done_q     <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            last_q         <= last_d;
            stuff_at_end_q <= stuff_at_end_d;
            bit_idx_q      <= bit_idx_d;
            ones_cnt_q     <= ones_cnt_d;
            dout_q         <= dout_d;
            dout_valid_q   <= dout_valid_d;
            pkt_done_q     <= pkt_done_d;
            underrun_q     <= underrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        last_d         = last_q;
        stuff_at_end_d = stuff_at_end_q;
        bit_idx_d      = bit_idx_q;
        ones_cnt_d     = ones_cnt_q;
        dout_d         = dout_q;
        dout_valid_d   = 1'b0;
        pkt_done_d     = 1'b0;
        underrun_d     = 1'b0;
        load_slot      = 1'b0;

        cur_bit    = shift_q[bit_idx_q];
        stuff_next = cur_bit && (ones_cnt_q == RUN_MAX);

        case (state_q)
            ST_IDLE: begin
                if (byte_valid) begin
                    shift_d        = byte_in;
                    last_d         = byte_last;
                    stuff_at_end_d = 1'b0;
                    bit_idx_d      = '0;
                    ones_cnt_d     = '0;
                    state_d        = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bit_en) begin
                    dout_d       = cur_bit;
                    dout_valid_d = 1'b1;
                    bit_idx_d    = (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + 1'b1;
                    ones_cnt_d   = cur_bit ? ones_cnt_q + 1'b1 : '0;
                    if (stuff_next) begin
                        // The byte boundary moves onto the stuff bit, so remember
                        // whether this stuff closes the current byte.
                        ones_cnt_d     = '0;
                        stuff_at_end_d = (bit_idx_q == LAST_IDX);
                        state_d        = ST_STUFF;
                    end else if (bit_idx_q == LAST_IDX) begin
                        load_slot = 1'b1;
                    end
                end
            end

            ST_STUFF: begin
                if (bit_en) begin
                    dout_d       = 1'b0;
                    dout_valid_d = 1'b1;
                    ones_cnt_d   = '0;
                    state_d      = ST_SHIFT;
                    load_slot    = stuff_at_end_q;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Load slot: the last bit of a byte is on its way out. A waiting byte
        // is taken here so the stream stays gap-free, and ones_cnt carries over.
        if (load_slot) begin
            stuff_at_end_d = 1'b0;
            if (last_q) begin
                state_d    = ST_IDLE;
                pkt_done_d = 1'b1;
            end else if (byte_valid) begin
                shift_d   = byte_in;
                last_d    = byte_last;
                bit_idx_d = '0;
                state_d   = ST_SHIFT;
            end else begin
                underrun_d = 1'b1;
                ones_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        end
    end

    assign byte_ready = rst_b && ((state_q == ST_IDLE) || (load_slot && !last_q));
    assign busy       = (state_q != ST_IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign pkt_done   = pkt_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_usb_tx_bit_stuffer.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_bit_stuffer
//   Bench for usb_tx_bit_stuffer. Expected bit streams are pushed to a
//   scoreboard queue when a byte is offered and popped as dout_valid pulses
//   appear. Single-byte packets come from a vector table; back-to-back bytes,
//   underrun and mid-packet reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_usb_tx_bit_stuffer;

    logic       clk;
    logic       rst_b;
    logic       bit_en;
    logic [7:0] byte_in;
    logic       byte_last;
    logic       byte_valid;
    logic       byte_ready;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       pkt_done;
    logic       underrun;

    usb_tx_bit_stuffer dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .bit_en     (bit_en),
        .byte_in    (byte_in),
        .byte_last  (byte_last),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .underrun   (underrun)
    );

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        int          period;
        logic [17:0] bits;
        int          len;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   en_period    = 1;
    int   en_cnt       = 0;
    bit   mon_en       = 0;
    bit   underrun_ok  = 0;
    logic prev_dout    = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit strobe: one high cycle every en_period cycles.
    initial begin
        bit_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (en_cnt >= en_period - 1) begin
                bit_en = 1'b1;
                en_cnt = 0;
            end else begin
                bit_en = 1'b0;
                en_cnt++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: wait expired, required event did not occur at %0t", name, $time);
    endtask

    task automatic pushExpected(input logic [17:0] bits, input int len, input logic pkt_end);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.b    = bits[i];
            e.last = pkt_end && (i == len - 1);
            sb.push_back(e);
        end
    endtask

    // Called aligned just after a posedge; returns aligned just after the
    // posedge on which the byte was taken.
    task automatic applyStimulus(input logic [7:0] b, input logic last, input bit drop_valid);
        bit taken = 0;
        byte_in    = b;
        byte_last  = last;
        byte_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (byte_ready) begin
                taken = 1;
                break;
            end
        end
        if (!taken) timeoutFail("handshake");
        @(posedge clk);
        #1;
        if (drop_valid || !taken) byte_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit done = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            timeoutFail(name);
            sb.delete();
        end else begin
            checkOutput({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (dout_valid) begin
                    if (sb.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL unexpected_bit: dout_valid=1 dout=%0b, required no bit at %0t",
                                 dout, $time);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("dout", {31'd0, dout}, {31'd0, e.b});
                        checkOutput("pkt_done", {31'd0, pkt_done}, {31'd0, e.last});
                    end
                end else begin
                    checkOutput("pkt_done_idle", {31'd0, pkt_done}, 32'd0);
                    if (busy && rst_b) checkOutput("dout_hold", {31'd0, dout}, {31'd0, prev_dout});
                end
                if (!underrun_ok) checkOutput("underrun_idle", {31'd0, underrun}, 32'd0);
            end
            prev_dout = dout;
        end
    end

    initial begin
        bit seen;
        int n_cyc;
        int n_val;

        // Single-byte packets: expected bits listed first-emitted in bit 0.
        vecs[0] = '{data: 8'h3F, period: 1, bits: 18'h0003F, len: 9};
        vecs[1] = '{data: 8'hFC, period: 1, bits: 18'h000FC, len: 9};
        vecs[2] = '{data: 8'h01, period: 4, bits: 18'h00001, len: 8};
        vecs[3] = '{data: 8'h00, period: 1, bits: 18'h00000, len: 8};
        vecs[4] = '{data: 8'hFF, period: 1, bits: 18'h001BF, len: 9};
        vecs[5] = '{data: 8'h7E, period: 2, bits: 18'h0007E, len: 9};

        // Reset with a byte offered: reset wins.
        rst_b      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h3F;
        byte_last  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_dout", {31'd0, dout}, 32'd1);
        checkOutput("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        checkOutput("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        rst_b      = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_rst_ready", {31'd0, byte_ready}, 32'd1);
        mon_en = 1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            en_period = vecs[v].period;
            pushExpected(vecs[v].bits, vecs[v].len, 1'b1);
            applyStimulus(vecs[v].data, 1'b1, 1'b1);
            waitDrain($sformatf("vec%0d", v));
        end

        // Two 0xFF bytes back to back: 18 bits with no gaps, stuff after
        // the 6th and 12th ones.
        $display("[TB] back-to-back 0xFF 0xFF");
        en_period = 1;
        pushExpected(18'h3DFBF, 18, 1'b1);
        seen  = 0;
        n_cyc = 0;
        n_val = 0;
        fork
            begin
                applyStimulus(8'hFF, 1'b0, 1'b0);
                applyStimulus(8'hFF, 1'b1, 1'b1);
            end
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (dout_valid) seen = 1;
                    if (seen) begin
                        n_cyc++;
                        if (dout_valid) n_val++;
                        if (pkt_done) break;
                    end
                end
            end
        join
        checkOutput("b2b_cycles", n_cyc, 32'd18);
        checkOutput("b2b_valids", n_val, 32'd18);
        waitDrain("b2b");

        // Underrun: non-last byte with nothing following it.
        $display("[TB] underrun 0xAA");
        en_period   = 3;
        underrun_ok = 1;
        pushExpected(18'h000AA, 8, 1'b0);
        applyStimulus(8'hAA, 1'b0, 1'b1);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #2;
            if (underrun) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            timeoutFail("underrun_wait");
        end else begin
            checkOutput("underrun_busy", {31'd0, busy}, 32'd0);
            checkOutput("underrun_ready", {31'd0, byte_ready}, 32'd1);
            checkOutput("underrun_pkt_done", {31'd0, pkt_done}, 32'd0);
            checkOutput("underrun_sb_left", sb.size(), 32'd0);
            @(negedge clk);
            checkOutput("underrun_pulse_len", {31'd0, underrun}, 32'd0);
        end
        underrun_ok = 0;
        sb.delete();
        @(posedge clk);
        #1;

        // Reset after three bits of 0xFF, then 0x3F must stuff after its 6th one.
        $display("[TB] reset mid-packet");
        en_period = 4;
        pushExpected(18'h00007, 3, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) timeoutFail("midrst_wait");
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_dout", {31'd0, dout}, 32'd1);
        checkOutput("midrst_dout_valid", {31'd0, dout_valid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_pkt_done", {31'd0, pkt_done}, 32'd0);
        checkOutput("midrst_ready", {31'd0, byte_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_b     = 1'b1;
        en_period = 1;
        sb.delete();
        pushExpected(18'h0003F, 9, 1'b1);
        applyStimulus(8'h3F, 1'b1, 1'b1);
        waitDrain("after_rst");

        repeat (5) @(posedge clk);
        checkOutput("sb_empty_end", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
